kernel_seq_ctrl: RTL and testbench
==================================

KERNEL_SEQ_CTRL -- requirements
Module: kernel_seq_ctrl

Interface
- REQ-001: Parameter CNTW, default 32, width of item-count configuration and beat counters.
- REQ-002: Parameter STALLW, default 16, width of the stall watchdog counter.
- REQ-003: clk  in  1  single clock; all logic on rising edge.
- REQ-004: rst  in  1  reset, synchronous, active-high.
- REQ-005: start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- REQ-006: num_items  in  CNTW  work items for the run; latched on accepted start.
- REQ-007: abort  in  1  terminates an active run.
- REQ-008: src_valid  in  1  upstream stream valid.
- REQ-009: src_ready  out  1  upstream stream ready.
- REQ-010: k_ivalid  out  1  kernel input valid.
- REQ-011: k_iready  in  1  kernel input ready.
- REQ-012: k_ovalid  in  1  kernel output valid.
- REQ-013: k_oready  out  1  kernel output ready (back-pressure into kernel).
- REQ-014: snk_valid  out  1  downstream valid.
- REQ-015: snk_ready  in  1  downstream ready.
- REQ-016: busy  out  1  high in RUN or DRAIN.
- REQ-017: done  out  1  one-cycle pulse at end of run.
- REQ-018: aborted  out  1  sticky; set when a run ends by abort or watchdog; cleared on next accepted start.
- REQ-019: issued_cnt  out  CNTW  beats accepted by kernel in current run.
- REQ-020: retired_cnt  out  CNTW  beats delivered downstream in current run.

Function
- REQ-021: FSM states IDLE, RUN, DRAIN, DONE.
- REQ-022: IDLE: start=1, num_items>0 -> RUN next cycle; latch N=num_items; clear both counters and aborted.
- REQ-023: IDLE: start=1, num_items=0 -> DONE; counters cleared; aborted cleared.
- REQ-024: start in any state other than IDLE ignored.
- REQ-025: Issue beat = RUN & src_valid & k_iready & (issued_cnt<N); issued_cnt increments by 1 per issue beat.
- REQ-026: RUN: k_ivalid = src_valid & (issued_cnt<N); src_ready = k_iready & (issued_cnt<N); both 0 in all other states.
- REQ-027: Retire beat = (RUN|DRAIN) & k_ovalid & snk_ready & (retired_cnt<N); retired_cnt increments by 1 per retire beat.
- REQ-028: RUN/DRAIN: snk_valid = k_ovalid & (retired_cnt<N); k_oready = snk_ready & (retired_cnt<N); both 0 in IDLE and DONE.
- REQ-029: RUN -> DRAIN on the cycle issued_cnt becomes N, unless retired_cnt also becomes N that cycle, then RUN -> DONE.
- REQ-030: DRAIN -> DONE on the cycle retired_cnt becomes N.
- REQ-031: Simultaneous issue and retire beats in one cycle both counted.
- REQ-032: abort=1 in RUN or DRAIN -> DONE next cycle, aborted set; abort takes priority over completion transitions; no beats counted that cycle.
- REQ-033: Watchdog: stall counter clears on any issue/retire beat or state change, increments otherwise in RUN/DRAIN; at all-ones -> DONE, aborted set.
- REQ-034: DONE lasts exactly one cycle, done=1, then IDLE.
- REQ-035: Counters hold their final values in DONE and IDLE until next accepted start.
- REQ-036: Counters never wrap: N bounds them; N = 2^CNTW-1 legal.
- REQ-037: Control path combinational from inputs to handshake outputs; zero-cycle added latency on data handshakes.

Reset
- REQ-038: rst=1 at any cycle, including mid-run, forces IDLE next edge.
- REQ-039: Reset values: src_ready=0, k_ivalid=0, k_oready=0, snk_valid=0, busy=0, done=0, aborted=0, issued_cnt=0, retired_cnt=0, N=0, stall counter=0.

Structure
- REQ-040: Shared package tybec_ctrl_pkg holds FSM state encoding and default CNTW/STALLW constants.
- REQ-041: One sub-module kernel_beat_cnt (clear, enable, limit compare, count output), instantiated twice for issue and retire counts.

Verification
- REQ-042: N=4, src_valid=1, k_iready=1, snk_ready=1, kernel latency 1 -> 4 issues, 4 retires, done pulse cycle after 4th retire, aborted=0.
- REQ-043: N=3, snk_ready=0 for 10 cycles after first issue -> k_oready=0, retired_cnt=0, no done; release -> completes with retired_cnt=3.
- REQ-044: N=2, src_valid held 1 for 5 cycles -> exactly 2 issues, src_ready=0 from cycle after 2nd issue, state DRAIN.
- REQ-045: start with num_items=0 -> done pulse 1 cycle after start, issued_cnt=retired_cnt=0, no handshake outputs asserted.
- REQ-046: N=8, abort after 3 issues -> DONE next cycle, aborted=1, issued_cnt=3; later start with N=1 clears aborted.
- REQ-047: rst asserted in DRAIN with issued_cnt=5 -> next cycle IDLE, all outputs at reset values; STALLW=4 with src_valid=0 -> watchdog DONE after 15 idle cycles, aborted=1.

Source files
------------

// File: rtl/tybec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tybec_ctrl_pkg
// Description : Shared definitions for the kernel sequencing controller:
//               FSM state encoding, default counter widths and a small
//               state-classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tybec_ctrl_pkg;

    // Default width of item-count configuration and beat counters.
    localparam int c_cntw_default   = 32;
    // Default width of the stall watchdog counter.
    localparam int c_stallw_default = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // States in which a run is in progress and the watchdog is armed.
    function automatic logic is_active(input seq_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : kernel_beat_cnt
// Description : Saturating-by-limit beat counter. Counts enabled beats while
//               below the configured limit, reports whether more beats are
//               allowed and whether the current beat reaches the limit.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_beat_cnt
    import tybec_ctrl_pkg::*;
#(
    parameter int CNTW = c_cntw_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [CNTW-1:0] i_limit,
    output logic [CNTW-1:0] o_count,
    output logic            o_below,
    output logic            o_reach
);

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    logic [CNTW-1:0] w_count_inc;

    // Next count and limit comparisons; the increment cannot overflow because
    // it is only taken while count_q < i_limit <= all-ones.
    always_comb begin
        w_count_inc = count_q + CNTW'(1);
        o_below     = (count_q < i_limit);
        o_reach     = i_en && o_below && (w_count_inc == i_limit);
        count_d     = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en && o_below) begin
            count_d = w_count_inc;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/kernel_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kernel_seq_ctrl
// Description : Run sequencer for a streaming kernel. Gates the source ->
//               kernel and kernel -> sink handshakes to exactly N items per
//               run, tracks issued/retired beats, supports abort and a stall
//               watchdog, and pulses done for one cycle at end of run.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_seq_ctrl
    import tybec_ctrl_pkg::*;
#(
    parameter int CNTW   = c_cntw_default,
    parameter int STALLW = c_stallw_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] num_items,
    input  logic            abort,
    input  logic            src_valid,
    output logic            src_ready,
    output logic            k_ivalid,
    input  logic            k_iready,
    input  logic            k_ovalid,
    output logic            k_oready,
    output logic            snk_valid,
    input  logic            snk_ready,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [CNTW-1:0] issued_cnt,
    output logic [CNTW-1:0] retired_cnt
);

    seq_state_e        state_q, state_d;
    logic [CNTW-1:0]   n_q, n_d;
    logic [STALLW-1:0] stall_q, stall_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              w_in_run;
    logic              w_active;
    logic              w_clr;
    logic              w_issue;
    logic              w_retire;
    logic              w_iss_below, w_iss_reach, w_iss_full;
    logic              w_ret_below, w_ret_reach, w_ret_full;
    logic [STALLW-1:0] w_stall_inc;
    logic              w_wd_fire;

    kernel_beat_cnt #(.CNTW(CNTW)) u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_issue),
        .i_limit (n_q),
        .o_count (issued_cnt),
        .o_below (w_iss_below),
        .o_reach (w_iss_reach)
    );

    kernel_beat_cnt #(.CNTW(CNTW)) u_retire_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_retire),
        .i_limit (n_q),
        .o_count (retired_cnt),
        .o_below (w_ret_below),
        .o_reach (w_ret_reach)
    );

    // Combinational handshake gating: zero added latency on the data path.
    // An aborting cycle still shows the handshakes but counts no beats.
    always_comb begin
        w_in_run  = (state_q == ST_RUN);
        w_active  = is_active(state_q);
        k_ivalid  = w_in_run && src_valid && w_iss_below;
        src_ready = w_in_run && k_iready && w_iss_below;
        snk_valid = w_active && k_ovalid && w_ret_below;
        k_oready  = w_active && snk_ready && w_ret_below;
        w_issue   = w_in_run && src_valid && k_iready && w_iss_below && !abort;
        w_retire  = w_active && k_ovalid && snk_ready && w_ret_below && !abort;
        // "Full" means the count equals N once this cycle's beat is taken.
        w_iss_full = w_iss_reach || !w_iss_below;
        w_ret_full = w_ret_reach || !w_ret_below;
    end

    // Next-state, watchdog and registered-output computation.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        aborted_d   = aborted_q;
        w_clr       = 1'b0;
        w_stall_inc = stall_q + STALLW'(1);
        w_wd_fire   = w_active && !w_issue && !w_retire && (w_stall_inc == '1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_clr     = 1'b1;
                    n_d       = num_items;
                    aborted_d = 1'b0;
                    state_d   = (num_items == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || w_wd_fire) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (w_iss_full) begin
                    // Retire side may finish on the same cycle as the last issue.
                    state_d = w_ret_full ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort || w_wd_fire) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (w_ret_full) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any progress or state change restarts the stall window.
        if ((state_d != state_q) || w_issue || w_retire || !w_active) begin
            stall_d = '0;
        end else begin
            stall_d = w_stall_inc;
        end

        busy_d = is_active(state_d);
        done_d = (state_d == ST_DONE);
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            stall_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            stall_q   <= stall_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_seq_ctrl
// Description : Directed self-checking bench for kernel_seq_ctrl with a
//               latency-1 kernel model; expected values computed by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_seq_ctrl;

    localparam int CNTW   = 8;
    localparam int STALLW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [CNTW-1:0] num_items;
    logic            abort;
    logic            src_valid;
    logic            src_ready;
    logic            k_ivalid;
    logic            k_iready;
    logic            k_ovalid;
    logic            k_oready;
    logic            snk_valid;
    logic            snk_ready;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [CNTW-1:0] issued_cnt;
    logic [CNTW-1:0] retired_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int kq     = 0;
    int ncyc;

    always #5 clk = ~clk;

    kernel_seq_ctrl #(.CNTW(CNTW), .STALLW(STALLW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_items   (num_items),
        .abort       (abort),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .k_ivalid    (k_ivalid),
        .k_iready    (k_iready),
        .k_ovalid    (k_ovalid),
        .k_oready    (k_oready),
        .snk_valid   (snk_valid),
        .snk_ready   (snk_ready),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .issued_cnt  (issued_cnt),
        .retired_cnt (retired_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flags {src_ready,k_ivalid,k_oready,snk_valid,busy,done,aborted}.
    function automatic logic [31:0] hs();
        return {25'd0, src_ready, k_ivalid, k_oready, snk_valid, busy, done, aborted};
    endfunction

    // One clock cycle; the kernel model holds items and offers them one cycle later.
    task automatic step();
        bit acc_in, acc_out;
        #1;
        acc_in  = k_ivalid && k_iready;
        acc_out = k_ovalid && k_oready;
        @(posedge clk);
        #1;
        kq = kq + (acc_in ? 1 : 0) - (acc_out ? 1 : 0);
        k_ovalid = (kq != 0);
        #1;
    endtask

    task automatic kclear();
        kq = 0;
        k_ovalid = 1'b0;
        #1;
    endtask

    task automatic do_start(input logic [CNTW-1:0] n);
        start = 1'b1;
        num_items = n;
        step();
        start = 1'b0;
        num_items = '0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (done !== 1'b1 && n < max) begin
            step();
            n++;
        end
        if (done !== 1'b1) chk("wait_done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_items = '0;
        src_valid = 1'b1; k_iready = 1'b1; k_ovalid = 1'b0; snk_ready = 1'b1;
        repeat (3) step();
        chk("reset_flags", hs(), 32'd0);
        chk("reset_issued", 32'(issued_cnt), 32'd0);
        chk("reset_retired", 32'(retired_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_flags", hs(), 32'd0);

        // Full-throughput run of 4 items.
        kclear();
        do_start(8'd4);
        chk("n4_busy", 32'(busy), 32'd1);
        chk("n4_kivalid", 32'(k_ivalid), 32'd1);
        chk("n4_issued0", 32'(issued_cnt), 32'd0);
        wait_done(20, ncyc);
        chk("n4_latency", 32'(ncyc), 32'd5);
        chk("n4_issued", 32'(issued_cnt), 32'd4);
        chk("n4_retired", 32'(retired_cnt), 32'd4);
        chk("n4_flags", hs(), 32'd2);
        step();
        chk("n4_done_pulse", 32'(done), 32'd0);
        chk("n4_hold_retired", 32'(retired_cnt), 32'd4);

        // Last issue and last retire on the same cycle: RUN goes straight to DONE.
        kclear();
        kq = 1; k_ovalid = 1'b1; #1;
        do_start(8'd1);
        wait_done(10, ncyc);
        chk("n1_direct_latency", 32'(ncyc), 32'd1);
        chk("n1_direct_counts", {16'(issued_cnt), 16'(retired_cnt)}, {16'd1, 16'd1});
        step();

        // Sink back-pressure on a 3-item run.
        kclear();
        snk_ready = 1'b0;
        do_start(8'd3);
        repeat (11) step();
        chk("bp_koready", 32'(k_oready), 32'd0);
        chk("bp_snkvalid", 32'(snk_valid), 32'd1);
        chk("bp_retired", 32'(retired_cnt), 32'd0);
        chk("bp_issued", 32'(issued_cnt), 32'd3);
        chk("bp_nodone", 32'({busy, done}), 32'd2);
        snk_ready = 1'b1;
        wait_done(20, ncyc);
        chk("bp_release_latency", 32'(ncyc), 32'd3);
        chk("bp_retired_final", 32'(retired_cnt), 32'd3);
        step();

        // Issue stops at N while the source keeps offering data.
        kclear();
        snk_ready = 1'b0;
        do_start(8'd2);
        step();
        step();
        chk("n2_issued", 32'(issued_cnt), 32'd2);
        chk("n2_srcready", 32'(src_ready), 32'd0);
        chk("n2_kivalid", 32'(k_ivalid), 32'd0);
        repeat (3) step();
        chk("n2_issued_held", 32'(issued_cnt), 32'd2);
        chk("n2_drain_state", 32'({busy, src_ready}), 32'd2);
        src_valid = 1'b0;
        snk_ready = 1'b1;
        wait_done(20, ncyc);
        chk("n2_drain_latency", 32'(ncyc), 32'd2);
        chk("n2_retired", 32'(retired_cnt), 32'd2);
        step();

        // Zero-item run completes immediately.
        kclear();
        src_valid = 1'b1;
        do_start(8'd0);
        chk("n0_flags", hs(), 32'd2);
        chk("n0_counts", {16'(issued_cnt), 16'(retired_cnt)}, 32'd0);
        step();
        chk("n0_done_pulse", 32'(done), 32'd0);

        // Abort after 3 issues; start during the run is ignored.
        kclear();
        snk_ready = 1'b0;
        do_start(8'd8);
        start = 1'b1;
        num_items = 8'd0;
        repeat (3) step();
        start = 1'b0;
        chk("abort_pre_issued", 32'(issued_cnt), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_flags", hs(), 32'd3);
        chk("abort_issued", 32'(issued_cnt), 32'd3);
        step();
        chk("abort_sticky", 32'({done, aborted}), 32'd1);
        kclear();
        snk_ready = 1'b1;
        do_start(8'd1);
        chk("abort_cleared", 32'(aborted), 32'd0);
        wait_done(10, ncyc);
        chk("n1_latency", 32'(ncyc), 32'd2);
        step();

        // Reset in DRAIN with 5 items issued.
        kclear();
        snk_ready = 1'b0;
        do_start(8'd5);
        repeat (5) step();
        chk("rst_pre_issued", 32'(issued_cnt), 32'd5);
        chk("rst_pre_drain", 32'({busy, src_ready}), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_flags", hs(), 32'd0);
        chk("rst_mid_counts", {16'(issued_cnt), 16'(retired_cnt)}, 32'd0);

        // Watchdog: no source data, 15 stalled RUN cycles then abort-done.
        kclear();
        src_valid = 1'b0;
        snk_ready = 1'b1;
        do_start(8'd4);
        wait_done(40, ncyc);
        chk("wd_latency", 32'(ncyc), 32'd15);
        chk("wd_flags", hs(), 32'd3);
        chk("wd_issued", 32'(issued_cnt), 32'd0);
        step();

        // Maximum legal N = 2^CNTW-1 without wrap.
        kclear();
        src_valid = 1'b1;
        do_start(8'd255);
        wait_done(300, ncyc);
        chk("nmax_latency", 32'(ncyc), 32'd256);
        chk("nmax_counts", {16'(issued_cnt), 16'(retired_cnt)}, {16'd255, 16'd255});
        chk("nmax_aborted", 32'(aborted), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
